// File: rtl/prog_loader_if.sv
// Host byte stream (valid/ready) plus PM write port of the program loader.
// slave = loader side, master = host / memory side.
interface prog_loader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 24
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] pm_addr;
  logic [DATA_WIDTH-1:0] pm_wdata;
  logic                  pm_we;

  modport slave (
    input  in_data, in_valid,
    output in_ready, pm_addr, pm_wdata, pm_we
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, pm_addr, pm_wdata, pm_we
  );
endinterface

// File: rtl/prog_loader.sv
// Loads a length-prefixed little-endian 24-bit word stream into program memory and
// holds the CPU until a clean load. Define LOADER_CHECKSUM_EN to add a trailing checksum byte.
module prog_loader #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  prog_loader_if.slave bus,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         cpu_run
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_B0, S_B1, S_B2, S_CSUM, S_DONE
  } state_t;

  state_t                state_reg;
  logic [15:0]           len_reg;
  logic [15:0]           idx_reg;
  logic [7:0]            b0_reg;
  logic [7:0]            b1_reg;
  logic                  ovf_reg;
  logic [ADDR_WIDTH-1:0] pm_addr_reg;
  logic [DATA_WIDTH-1:0] pm_wdata_reg;
  logic                  pm_we_reg;
  logic                  done_reg;
  logic                  err_reg;
  logic                  cpu_run_reg;
  logic                  in_ready_int;
  logic                  hs;
  logic                  word_ovf;
  logic                  last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum_reg;
  logic [7:0]            csum_total;
`endif

  assign in_ready_int = (state_reg == S_LEN_LO) || (state_reg == S_LEN_HI) ||
                        (state_reg == S_B0) || (state_reg == S_B1) ||
                        (state_reg == S_B2) || (state_reg == S_CSUM);
  assign busy         = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign hs           = bus.in_valid & in_ready_int;

  // Any index bit above the address range means the word has no PM slot; it is dropped,
  // so the address never wraps onto already-written low words.
  assign word_ovf  = (idx_reg >> ADDR_WIDTH) != 16'd0;
  assign last_word = (idx_reg + 16'd1) == len_reg;

`ifdef LOADER_CHECKSUM_EN
  assign csum_total = csum_reg + bus.in_data;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      len_reg      <= '0;
      idx_reg      <= '0;
      b0_reg       <= '0;
      b1_reg       <= '0;
      ovf_reg      <= 1'b0;
      pm_addr_reg  <= '0;
      pm_wdata_reg <= '0;
      pm_we_reg    <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      cpu_run_reg  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_reg     <= '0;
`endif
    end else begin
      pm_we_reg <= 1'b0;
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_reg   <= S_LEN_LO;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            cpu_run_reg <= 1'b0;
            idx_reg     <= '0;
            ovf_reg     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_reg    <= '0;
`endif
          end
        end
        S_LEN_LO: begin
          if (hs) begin
            len_reg[7:0] <= bus.in_data;
            state_reg    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (hs) begin
            len_reg[15:8] <= bus.in_data;
            if ({bus.in_data, len_reg[7:0]} == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state_reg   <= S_CSUM;
`else
              state_reg   <= S_DONE;
              done_reg    <= 1'b1;
              err_reg     <= ovf_reg;
              cpu_run_reg <= ~ovf_reg;
`endif
            end else begin
              state_reg <= S_B0;
            end
          end
        end
        S_B0: begin
          if (hs) begin
            b0_reg    <= bus.in_data;
            state_reg <= S_B1;
          end
        end
        S_B1: begin
          if (hs) begin
            b1_reg    <= bus.in_data;
            state_reg <= S_B2;
          end
        end
        S_B2: begin
          if (hs) begin
            idx_reg <= idx_reg + 16'd1;
            if (!word_ovf) begin
              pm_addr_reg  <= idx_reg[ADDR_WIDTH-1:0];
              pm_wdata_reg <= {bus.in_data, b1_reg, b0_reg};
              pm_we_reg    <= 1'b1;
            end else begin
              ovf_reg <= 1'b1;
            end
            if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
              state_reg   <= S_CSUM;
`else
              state_reg   <= S_DONE;
              done_reg    <= 1'b1;
              err_reg     <= ovf_reg | word_ovf;
              cpu_run_reg <= ~(ovf_reg | word_ovf);
`endif
            end else begin
              state_reg <= S_B0;
            end
          end
        end
        S_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
          // Sum of every byte including the check byte must come to zero mod 256.
          if (hs) begin
            state_reg   <= S_DONE;
            done_reg    <= 1'b1;
            err_reg     <= ovf_reg | (csum_total != 8'd0);
            cpu_run_reg <= ~(ovf_reg | (csum_total != 8'd0));
          end
`else
          state_reg <= S_IDLE;
`endif
        end
        default: state_reg <= S_IDLE;
      endcase
`ifdef LOADER_CHECKSUM_EN
      if (hs && (state_reg != S_CSUM))
        csum_reg <= csum_total;
`endif
    end
  end

  assign bus.in_ready = in_ready_int;
  assign bus.pm_addr  = pm_addr_reg;
  assign bus.pm_wdata = pm_wdata_reg;
  assign bus.pm_we    = pm_we_reg;
  assign done         = done_reg;
  assign err          = err_reg;
  assign cpu_run      = cpu_run_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader with a 4-word PM so overflow is reachable;
// follows LOADER_CHECKSUM_EN when defined.
module tb_prog_loader;
  localparam int AW = 2;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic rst;
  logic start;
  logic busy, done, err, cpu_run;

  prog_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(24)) bus ();

  prog_loader #(.DATA_WIDTH(24), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus.slave),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .cpu_run (cpu_run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [AW+23:0] exp_q [$];
  logic [23:0]    words [$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // PM write monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && bus.pm_we) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_we", 32'd1, 32'd0);
      end else begin
        logic [AW+23:0] e;
        e = exp_q.pop_front();
        check_val("pm_addr", 32'(bus.pm_addr), 32'(e[AW+23:24]));
        check_val("pm_wdata", 32'(bus.pm_wdata), 32'(e[23:0]));
        $display("write addr %0d data %06h", bus.pm_addr, bus.pm_wdata);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Gapped bytes spend a cycle with valid low, junk data and a start pulse, all to be ignored.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int k;
    if (gap) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'hEE;
      start        = 1'b1;
      @(negedge clk);
      start        = 1'b0;
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    k = 0;
    while (!bus.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k == 50) check_val("hs_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic send_load(input bit gap, input bit bad_csum);
    int n;
    logic [7:0] sum;
    n   = words.size();
    sum = 8'd0;
    send_byte(n[7:0], gap);
    sum = sum + n[7:0];
    send_byte(n[15:8], gap);
    sum = sum + n[15:8];
    for (int i = 0; i < n; i++) begin
      logic [23:0] w;
      w = words[i];
      if (i < DEPTH) exp_q.push_back({i[AW-1:0], w});
      send_byte(w[7:0], gap);
      send_byte(w[15:8], gap);
      send_byte(w[23:16], gap);
      sum = sum + w[7:0] + w[15:8] + w[23:16];
    end
`ifdef LOADER_CHECKSUM_EN
    sum = 8'd0 - sum;
    send_byte(bad_csum ? sum + 8'd1 : sum, gap);
`else
    if (bad_csum) $display("checksum disabled, bad_csum ignored");
`endif
  endtask

  // Call at the negedge following the final byte.
  task automatic check_end(input string tag, input bit exp_err);
    check_val({tag, "_done"}, 32'(done), 32'd1);
    check_val({tag, "_err"}, 32'(err), 32'(exp_err));
    check_val({tag, "_cpu_run"}, 32'(cpu_run), 32'(!exp_err));
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    repeat (3) @(negedge clk);
    check_val({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    $display("load %s done=%0b err=%0b cpu_run=%0b", tag, done, err, cpu_run);
  endtask

  task automatic check_idle_zero(input string tag);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_done"}, 32'(done), 32'd0);
    check_val({tag, "_err"}, 32'(err), 32'd0);
    check_val({tag, "_cpu_run"}, 32'(cpu_run), 32'd0);
    check_val({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check_val({tag, "_pm_we"}, 32'(bus.pm_we), 32'd0);
    check_val({tag, "_pm_addr"}, 32'(bus.pm_addr), 32'd0);
    check_val({tag, "_pm_wdata"}, 32'(bus.pm_wdata), 32'd0);
  endtask

  initial begin
    rst          = 1'b0;
    start        = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_zero("reset");

    pulse_start();
    check_val("start_in_ready", 32'(bus.in_ready), 32'd1);
    check_val("start_busy", 32'(busy), 32'd1);

    // Two words back to back: final write and done coincide
    words = '{24'h123456, 24'hAABBCC};
    send_load(1'b0, 1'b0);
    @(negedge clk);
`ifndef LOADER_CHECKSUM_EN
    check_val("last_we_with_done", 32'(bus.pm_we), 32'd1);
`endif
    check_end("two_words", 1'b0);

    // Same stream with valid gaps and ignored start pulses, restarting from DONE
    pulse_start();
    check_val("restart_done_clr", 32'(done), 32'd0);
    check_val("restart_cpu_run_clr", 32'(cpu_run), 32'd0);
    send_load(1'b1, 1'b0);
    @(negedge clk);
    check_end("gapped", 1'b0);

    // Empty load
    words = {};
    pulse_start();
    send_load(1'b0, 1'b0);
    @(negedge clk);
    check_end("n_zero", 1'b0);

    // Five words into a four-word PM: fifth consumed, not written
    words = '{24'h000011, 24'h000022, 24'h000033, 24'h000044, 24'h000055};
    pulse_start();
    send_load(1'b0, 1'b0);
    @(negedge clk);
    check_end("overflow", 1'b1);
    check_val("overflow_addr_hold", 32'(bus.pm_addr), 32'd3);
    check_val("overflow_data_hold", 32'(bus.pm_wdata), 32'h000044);

    // Reset after B1 of word 0, then a fresh load
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h56, 1'b0);
    send_byte(8'h34, 1'b0);
    #2 rst = 1'b0;
    #1 check_idle_zero("midload_rst");
    @(negedge clk);
    rst = 1'b1;
    words = '{24'h123456, 24'hAABBCC};
    pulse_start();
    send_load(1'b0, 1'b0);
    @(negedge clk);
    check_end("after_rst", 1'b0);

`ifdef LOADER_CHECKSUM_EN
    // 01 00 01 02 03 F9 is clean; FA as the check byte flags err but still writes
    words = '{24'h030201};
    pulse_start();
    send_load(1'b0, 1'b0);
    @(negedge clk);
    check_end("csum_ok", 1'b0);
    pulse_start();
    send_load(1'b0, 1'b1);
    @(negedge clk);
    check_end("csum_bad", 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
